// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot-time EEPROM-to-SRAM copier.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        WRITE,
        DONE
    } bootState_t;

    localparam int unsigned BOOT_CMD_BITS  = 8;
    localparam int unsigned BOOT_ADDR_BITS = 16;
    localparam int unsigned BOOT_WORD_BITS = 16;

    // Shift engine is as wide as the widest field it moves.
    localparam int unsigned SHIFT_W  = 16;
    localparam int unsigned BITCNT_W = 5;

    localparam logic [BOOT_CMD_BITS-1:0] READ_CMD_DEFAULT = 8'h03;

    typedef struct packed {
        logic [BOOT_ADDR_BITS-1:0] addr;
        logic [BOOT_WORD_BITS-1:0] data;
    } memWrite_t;

    // Left-justify the opcode so the shifter can send it MSB-first.
    function automatic logic [SHIFT_W-1:0] cmdWord(input logic [BOOT_CMD_BITS-1:0] cmd);
        return {cmd, (SHIFT_W - BOOT_CMD_BITS)'(0)};
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Storage-side SPI pins and memory-side write port of the boot copier.
interface boot_loader_if;
    import boot_pkg::*;

    logic                      o_spiCLK;
    logic                      o_spiMOSI;
    logic                      o_spiCSn;
    logic                      i_spiMISO;
    logic [BOOT_ADDR_BITS-1:0] o_memAddr;
    logic [BOOT_WORD_BITS-1:0] o_memData;
    logic                      o_memWr;
    logic                      o_memEn;

    modport master (
        output o_spiCLK, o_spiMOSI, o_spiCSn,
        output o_memAddr, o_memData, o_memWr, o_memEn,
        input  i_spiMISO
    );

    modport slave (
        input  o_spiCLK, o_spiMOSI, o_spiCSn,
        input  o_memAddr, o_memData, o_memWr, o_memEn,
        output i_spiMISO
    );
endinterface

// File: rtl/boot_loader_spi_shifter.sv
// SPI mode-0 bit engine: SCLK divider, bit counter, MSB-first MOSI shift-out
// and MISO shift-in, driven through a load/go/done handshake.
module boot_spi_shifter
    import boot_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                load,
    input  logic                go,
    input  logic [SHIFT_W-1:0]  txData,
    input  logic [BITCNT_W-1:0] nBits,
    input  logic                miso,
    output logic                sclk,
    output logic                mosi,
    output logic [SHIFT_W-1:0]  rxData,
    output logic                done_c
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]    divCnt;
    logic [SHIFT_W-1:0]  txReg;
    logic [SHIFT_W-1:0]  rxReg;
    logic [BITCNT_W-1:0] bitsLeft;
    logic                active;
    logic                halfEnd;

    assign halfEnd = active && go && (divCnt == DIV_LAST);
    // Final falling edge of the request; a same-cycle load chains with no gap.
    assign done_c  = halfEnd && sclk && (bitsLeft == BITCNT_W'(1));
    assign rxData  = rxReg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            divCnt   <= '0;
            txReg    <= '0;
            rxReg    <= '0;
            bitsLeft <= '0;
            active   <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
        end else if (load) begin
            divCnt   <= '0;
            sclk     <= 1'b0;
            mosi     <= txData[SHIFT_W-1];
            txReg    <= {txData[SHIFT_W-2:0], 1'b0};
            bitsLeft <= nBits;
            active   <= 1'b1;
        end else if (active && go) begin
            if (halfEnd) begin
                divCnt <= '0;
                sclk   <= ~sclk;
                if (!sclk) begin
                    rxReg <= {rxReg[SHIFT_W-2:0], miso};
                end else begin
                    bitsLeft <= bitsLeft - 1'b1;
                    if (bitsLeft == BITCNT_W'(1)) begin
                        active <= 1'b0;
                        mosi   <= 1'b0;
                    end else begin
                        mosi  <= txReg[SHIFT_W-1];
                        txReg <= {txReg[SHIFT_W-2:0], 1'b0};
                    end
                end
            end else begin
                divCnt <= divCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Boot-time copier: reads NUM_WORDS 16-bit words from the SPI EEPROM with one
// continuous sequential read and writes them into SRAM from address 0 upward.
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned              NUM_WORDS = 16'hFFFF,
    parameter int unsigned              CLK_DIV   = 2,
    parameter logic [BOOT_CMD_BITS-1:0] READ_CMD  = READ_CMD_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_start,
    boot_loader_if.master bus,
    output logic          o_busy,
    output logic          o_isBooted
);

    localparam logic [BOOT_ADDR_BITS-1:0] LAST_ADDR = BOOT_ADDR_BITS'(NUM_WORDS - 1);

    bootState_t state, stateNext;
    memWrite_t  memReq, memReqNext;
    logic       memStrobe, memStrobeNext;
    logic       csn, csnNext;
    logic       busyNext, bootedNext;

    logic                shLoad, shGo, shDone_c;
    logic [SHIFT_W-1:0]  shTx, shRx;
    logic [BITCNT_W-1:0] shBits;

    boot_spi_shifter #(.CLK_DIV(CLK_DIV)) uShift (
        .clk    (i_clk),
        .rstn   (i_rstn),
        .load   (shLoad),
        .go     (shGo),
        .txData (shTx),
        .nBits  (shBits),
        .miso   (bus.i_spiMISO),
        .sclk   (bus.o_spiCLK),
        .mosi   (bus.o_spiMOSI),
        .rxData (shRx),
        .done_c (shDone_c)
    );

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= IDLE;
            memReq     <= '0;
            memStrobe  <= 1'b0;
            csn        <= 1'b1;
            o_busy     <= 1'b0;
            o_isBooted <= 1'b0;
        end else begin
            state      <= stateNext;
            memReq     <= memReqNext;
            memStrobe  <= memStrobeNext;
            csn        <= csnNext;
            o_busy     <= busyNext;
            o_isBooted <= bootedNext;
        end
    end

    // Next state, next outputs and shifter requests.
    always_comb begin
        stateNext     = state;
        memReqNext    = memReq;
        memStrobeNext = 1'b0;
        csnNext       = csn;
        busyNext      = o_busy;
        bootedNext    = o_isBooted;
        shLoad        = 1'b0;
        shGo          = 1'b0;
        shTx          = '0;
        shBits        = '0;

        case (state)
            IDLE: begin
                if (i_start) begin
                    stateNext = CMD;
                    csnNext   = 1'b0;
                    busyNext  = 1'b1;
                    shLoad    = 1'b1;
                    shTx      = cmdWord(READ_CMD);
                    shBits    = BITCNT_W'(BOOT_CMD_BITS);
                end
            end
            CMD: begin
                shGo = 1'b1;
                if (shDone_c) begin
                    stateNext = ADDR;
                    shLoad    = 1'b1;
                    shBits    = BITCNT_W'(BOOT_ADDR_BITS);
                end
            end
            ADDR: begin
                shGo = 1'b1;
                if (shDone_c) begin
                    stateNext = DATA;
                    shLoad    = 1'b1;
                    shBits    = BITCNT_W'(BOOT_WORD_BITS);
                end
            end
            DATA: begin
                shGo = 1'b1;
                if (shDone_c) begin
                    stateNext       = WRITE;
                    memStrobeNext   = 1'b1;
                    memReqNext.data = shRx;
                end
            end
            WRITE: begin
                // SCLK stays low here, so the EEPROM read is only paused.
                if (memReq.addr == LAST_ADDR) begin
                    stateNext  = DONE;
                    csnNext    = 1'b1;
                    busyNext   = 1'b0;
                    bootedNext = 1'b1;
                end else begin
                    stateNext       = DATA;
                    memReqNext.addr = memReq.addr + 1'b1;
                    shLoad          = 1'b1;
                    shBits          = BITCNT_W'(BOOT_WORD_BITS);
                end
            end
            DONE: begin
                stateNext = DONE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign bus.o_spiCSn  = csn;
    assign bus.o_memAddr = memReq.addr;
    assign bus.o_memData = memReq.data;
    assign bus.o_memWr   = memStrobe;
    assign bus.o_memEn   = memStrobe;

endmodule
